// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: computes {Cout,S} = A + B + Cin with one full adder,
// LSB first, one bit per clock, behind a valid/ready handshake on each side.

module serial_add_half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic halfSum, genLow, sumBit, genHigh, carryNext;

    // Single full adder built from two half adders; the carry is the majority function.
    serial_add_half_adder u_ha_low (
        .a_i     (a_q[0]),
        .b_i     (b_q[0]),
        .sum_o   (halfSum),
        .carry_o (genLow)
    );

    serial_add_half_adder u_ha_high (
        .a_i     (halfSum),
        .b_i     (carry_q),
        .sum_o   (sumBit),
        .carry_o (genHigh)
    );

    assign carryNext = genLow | genHigh;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at S[0].
                s_d     = {sumBit, s_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = carryNext;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = carryNext;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver queues expected sums on accept,
// a monitor pops and compares whenever a result is consumed.

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int tests = 0;
    int fails = 0;
    int issued = 0;
    int results = 0;
    int edgeCnt = 0;
    int readyMode = 0;
    bit monitorEn = 0;

    logic [WIDTH:0] expQ[$];
    int             latQ[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edgeCnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Waits for an IDLE cycle, presents one operand set and records the expected result.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic [WIDTH:0] expected);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: in_ready stuck at %b, required 1", in_ready);
            return;
        end
        A        = a;
        B        = b;
        Cin      = c;
        in_valid = 1'b1;
        expQ.push_back(expected);
        latQ.push_back(edgeCnt + 1);
        issued++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = WIDTH'($urandom);
        B        = WIDTH'($urandom);
        Cin      = 1'b0;
    endtask

    task automatic waitOutValid();
        int guard;
        guard = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            tests++;
            fails++;
            $display("[TB] FAIL out_valid_timeout: out_valid=%b, required 1", out_valid);
        end
    endtask

    // Monitor: drives out_ready and checks each result exactly once when it is taken.
    initial begin
        bit             seenCur;
        logic [WIDTH:0] exp;
        int             lat;
        seenCur   = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (monitorEn && out_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL spurious_result: S=0x%0h Cout=%b with no operation pending", S, Cout);
                end else begin
                    if (!seenCur) begin
                        seenCur = 1;
                        lat = latQ.pop_front();
                        checkOutput("latency", 32'(edgeCnt - lat), WIDTH);
                    end
                    if (out_ready) begin
                        exp = expQ.pop_front();
                        checkOutput("sum", 32'(S), 32'(exp[WIDTH-1:0]));
                        checkOutput("cout", 32'(Cout), 32'(exp[WIDTH]));
                        seenCur = 0;
                        results++;
                    end
                end
            end
        end
    end

    initial begin
        int busyCnt;
        int ovCnt;
        int guard;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;

        reset    = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_S", 32'(S), 0);
        checkOutput("rst_Cout", 32'(Cout), 0);
        reset     = 1'b0;
        monitorEn = 1;

        // Zero operands; busy must last exactly WIDTH cycles.
        applyStimulus(8'h00, 8'h00, 1'b0, 9'h000);
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busyCnt++;
            else break;
        end
        checkOutput("busy_cycles", 32'(busyCnt), WIDTH);

        applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100);
        applyStimulus(8'hA5, 8'h5A, 1'b1, 9'h100);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        applyStimulus(8'h12, 8'h34, 1'b0, 9'h046);
        applyStimulus(8'h80, 8'h80, 1'b0, 9'h100);
        applyStimulus(8'h0F, 8'hF0, 1'b1, 9'h100);

        // Backpressure: result must hold while new operands are offered and ignored.
        guard = 0;
        while (expQ.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        readyMode = 1;
        applyStimulus(8'h3C, 8'h0F, 1'b1, 9'h04C);
        waitOutValid();
        for (int i = 0; i < 5; i++) begin
            A        = 8'h11;
            B        = 8'h22;
            Cin      = 1'b1;
            in_valid = 1'b1;
            checkOutput("bp_S", 32'(S), 32'h4C);
            checkOutput("bp_Cout", 32'(Cout), 0);
            checkOutput("bp_in_ready", 32'(in_ready), 0);
            checkOutput("bp_out_valid", 32'(out_valid), 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        readyMode = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("consume_in_ready", 32'(in_ready), 1);
        checkOutput("consume_busy", 32'(busy), 0);
        checkOutput("consume_out_valid", 32'(out_valid), 0);
        in_valid = 1'b0;

        // Reset during the third RUN cycle aborts the operation silently.
        applyStimulus(8'hC3, 8'h3C, 1'b1, 9'h100);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        latQ.delete();
        issued--;
        checkOutput("abort_in_ready", 32'(in_ready), 1);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_S", 32'(S), 0);
        checkOutput("abort_Cout", 32'(Cout), 0);
        ovCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) ovCnt++;
            @(negedge clk);
        end
        checkOutput("abort_no_out_valid", 32'(ovCnt), 0);

        // Random traffic with gaps on both sides.
        @(posedge clk);
        #1;
        readyMode = 2;
        for (int n = 0; n < 200; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(ra, rb, rc, (WIDTH + 1)'(ra) + (WIDTH + 1)'(rb) + (WIDTH + 1)'(rc));
        end

        guard = 0;
        while (expQ.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_queue", 32'(expQ.size()), 0);
        checkOutput("result_count", 32'(results), 32'(issued));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
